serial_adder: RTL and testbench

- Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
- Uses a single registered-carry full-adder cell.
- Successor to the single-bit combinational full adder, for area-constrained arithmetic in the datapath.
- Start/busy/done handshake. The result is held stable until the next operation completes.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_fa_cell.sv | 26 ++
 rtl/serial_adder.sv | 175 +++++++++++++++++
 tb/tb_serial_adder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and limits for the bit-serial adder.
//   - state_t   : controller states (IDLE -> RUN -> DONE -> IDLE)
//   - MAX_WIDTH : largest operand width the adder accepts
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam int MAX_WIDTH = 64;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Combinational 1-bit full adder; the arithmetic core of serial_adder.
//   Ports:
//     a, b  in  operand bits
//     ci    in  carry in
//     s     out sum bit
//     co    out carry out
// -----------------------------------------------------------------------------
module fa_cell
   import serial_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic half_s;

   assign half_s = a ^ b;
   assign s      = half_s ^ ci;
   assign co     = (a & b) | (ci & half_s);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: {cout,sum} = a + b + cin, processed LSB first, one bit
//   per clock through a single full-adder cell with a registered carry.
//   A start accepted in IDLE captures the operands; WIDTH RUN cycles follow,
//   then a one-cycle done pulse. sum/cout (and ovf) update only at the
//   completing edge and hold until the next completion.
//
//   Parameter:
//     WIDTH  operand/sum width, 1..MAX_WIDTH (default 8)
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   asynchronous, active-high reset
//     start  in   request, sampled only in IDLE
//     a, b   in   operands (WIDTH bits), captured on accepted start
//     cin    in   carry in, captured on accepted start
//     busy   out  high exactly while in RUN
//     done   out  one-cycle pulse when the result is valid
//     sum    out  registered sum (WIDTH bits)
//     cout   out  registered carry out
//     ovf    out  registered two's-complement overflow
//                 (present only when SERIAL_ADDER_OVF_EN is defined)
//
//   Build option: define SERIAL_ADDER_OVF_EN to add the ovf output.
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   // ---------------------------------------------------------------------------
   // Elaboration-time legality check
   // ---------------------------------------------------------------------------
   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_adder: WIDTH=%0d outside legal range 1..%0d", WIDTH, MAX_WIDTH);
   end

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] sum_sh_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q;
`endif

   // ---------------------------------------------------------------------------
   // Full-adder cell on the current LSBs and the running carry
   // ---------------------------------------------------------------------------
   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] sum_sh_d;

   fa_cell u_fa (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // The new sum bit enters at the MSB, so after WIDTH shifts the first
   // (LSB) result bit has travelled down to bit 0.
   if (WIDTH == 1) begin : g_sum_w1
      assign sum_sh_d = fa_s;
   end else begin : g_sum_wn
      assign sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
   end

   // ---------------------------------------------------------------------------
   // Controller and datapath
   // ---------------------------------------------------------------------------
   // NOTE: every register here uses non-blocking assignment so all of them
   // see the pre-edge values of each other (the shift chain depends on it).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the shift registers are reset too, not just the control
         // state, so an aborted operation leaves no stale bits behind.
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end

            S_RUN: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               sum_sh_q <= sum_sh_d;
               carry_q  <= fa_co;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  // Last bit: publish the result straight from the cell so
                  // sum/cout change on this edge and no earlier.
                  sum_q   <= sum_sh_d;
                  cout_q  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry_q is the carry into the MSB, fa_co the carry out.
                  ovf_q   <= carry_q ^ fa_co;
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end

            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Three instances of serial_adder (WIDTH = 8, 1, 3) share a clock and reset.
//   A driver issues directed operations and pushes the expected {cout,sum}
//   (and ovf) into a scoreboard queue; a monitor pops and compares whenever a
//   done pulse appears. The driver also checks latency, busy length, the
//   done count and that no partial result leaks out during RUN.
//   Define SERIAL_ADDER_OVF_EN to also check the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // Instance 0: WIDTH=8
   logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   // Instance 1: WIDTH=1
   logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
   logic [0:0] a1 = '0, b1 = '0, sum1;
   // Instance 2: WIDTH=3
   logic       start3 = 1'b0, cin3 = 1'b0, busy3, done3, cout3;
   logic [2:0] a3 = '0, b3 = '0, sum3;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf8, ovf1, ovf3;
`endif

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf1)
`endif
   );

   serial_adder #(.WIDTH(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
      .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf3)
`endif
   );

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         dut;
      logic [8:0] res;
      logic       ovf;
   } exp_t;

   exp_t       sb_q[$];
   logic [8:0] prev_res [3];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int wv(input int d);
      case (d)
         0:       return 8;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic logic [8:0] get_res(input int d);
      case (d)
         0:       return {cout8, sum8};
         1:       return 9'({cout1, sum1});
         default: return 9'({cout3, sum3});
      endcase
   endfunction

   function automatic logic get_done(input int d);
      case (d)
         0:       return done8;
         1:       return done1;
         default: return done3;
      endcase
   endfunction

   function automatic logic get_busy(input int d);
      case (d)
         0:       return busy8;
         1:       return busy1;
         default: return busy3;
      endcase
   endfunction

`ifdef SERIAL_ADDER_OVF_EN
   function automatic logic get_ovf(input int d);
      case (d)
         0:       return ovf8;
         1:       return ovf1;
         default: return ovf3;
      endcase
   endfunction
`endif

   // Signed overflow of a W-bit add: operands agree in sign, result does not.
   function automatic logic exp_ovf(input int w, input logic [7:0] av, input logic [7:0] bv,
                                    input logic [8:0] res);
      return (av[w-1] == bv[w-1]) && (res[w-1] != av[w-1]);
   endfunction

   task automatic set_in(input int d, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic st);
      case (d)
         0: begin a8 = av;      b8 = bv;      cin8 = cv; start8 = st; end
         1: begin a1 = av[0:0]; b1 = bv[0:0]; cin1 = cv; start1 = st; end
         default: begin a3 = av[2:0]; b3 = bv[2:0]; cin3 = cv; start3 = st; end
      endcase
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compares every done pulse against the scoreboard head
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            if (get_done(d)) begin
               if (sb_q.size() == 0) begin
                  check($sformatf("spurious_done_w%0d", wv(d)), 64'(sb_q.size()), 64'd1);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  check($sformatf("done_instance_w%0d", wv(d)), 64'(d), 64'(e.dut));
                  check($sformatf("result_w%0d", wv(d)), 64'(get_res(d)), 64'(e.res));
`ifdef SERIAL_ADDER_OVF_EN
                  check($sformatf("ovf_w%0d", wv(d)), 64'(get_ovf(d)), 64'(e.ovf));
`endif
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver: one operation with timing checks
   // ---------------------------------------------------------------------------
   task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [8:0] res, input logic ovf_exp,
                         input bit hold_start, input bit zero_after);
      int w       = wv(d);
      int done_k  = 0;
      int n_done  = 0;
      int n_busy  = 0;
      bit part_ok = 1'b1;
      exp_t e;

      @(negedge clk);
      set_in(d, av, bv, cv, 1'b1);
      e.dut = d;
      e.res = res;
      e.ovf = ovf_exp;
      sb_q.push_back(e);

      // Edge k=1 is the start edge; done is due after edge k=w+1.
      for (int k = 1; k <= w + 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) begin
            if (zero_after) set_in(d, 8'h00, 8'h00, 1'b0, hold_start);
            else            set_in(d, av, bv, cv, hold_start);
         end
         // With start held, keep it up through the edge that samples DONE.
         if (k == w + 2) set_in(d, 8'h00, 8'h00, 1'b0, 1'b0);
         if (get_busy(d)) n_busy++;
         if (get_done(d)) begin
            n_done++;
            if (done_k == 0) done_k = k;
         end
         if (done_k == 0 && get_res(d) !== prev_res[d]) part_ok = 1'b0;
      end

      check($sformatf("done_latency_w%0d", w), 64'(done_k), 64'(w + 1));
      check($sformatf("busy_cycles_w%0d", w), 64'(n_busy), 64'(w));
      check($sformatf("done_count_w%0d", w), 64'(n_done), 64'd1);
      check($sformatf("no_partial_w%0d", w), 64'(part_ok), 64'd1);
      check($sformatf("result_hold_w%0d", w), 64'(get_res(d)), 64'(res));
      prev_res[d] = res;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("%s_busy_w%0d", tag, wv(d)), 64'(get_busy(d)), 64'd0);
         check($sformatf("%s_done_w%0d", tag, wv(d)), 64'(get_done(d)), 64'd0);
         check($sformatf("%s_result_w%0d", tag, wv(d)), 64'(get_res(d)), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
         check($sformatf("%s_ovf_w%0d", tag, wv(d)), 64'(get_ovf(d)), 64'd0);
`endif
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      for (int d = 0; d < 3; d++) prev_res[d] = '0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset_initial");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed WIDTH=8 vectors (hand-computed).
      run_op(0, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b0, 1'b0);  // full carry ripple
      run_op(0, 8'h5A, 8'h33, 1'b1, 9'h08E, 1'b1, 1'b0, 1'b1);  // cin path, inputs zeroed after start
      run_op(0, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 1'b0, 1'b0);  // positive overflow
      run_op(0, 8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 1'b0, 1'b0);  // negative overflow
      run_op(0, 8'h12, 8'h34, 1'b0, 9'h046, 1'b0, 1'b1, 1'b0);  // start held through RUN/DONE
      run_op(0, 8'h00, 8'h00, 1'b1, 9'h001, 1'b0, 1'b0, 1'b0);  // carry-in only

      // WIDTH=1: full truth table.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] av, bv;
         logic       cv;
         logic [8:0] r;
         av = 8'(i & 1);
         bv = 8'((i >> 1) & 1);
         cv = 1'((i >> 2) & 1);
         r  = 9'(av) + 9'(bv) + 9'(cv);
         run_op(1, av, bv, cv, r, exp_ovf(1, av, bv, r), 1'b0, 1'b0);
      end

      // WIDTH=3: every {a,b,cin}.
      for (int i = 0; i < 128; i++) begin
         logic [7:0] av, bv;
         logic       cv;
         logic [8:0] r;
         av = 8'(i & 7);
         bv = 8'((i >> 3) & 7);
         cv = 1'((i >> 6) & 1);
         r  = 9'(av) + 9'(bv) + 9'(cv);
         run_op(2, av, bv, cv, r, exp_ovf(3, av, bv, r), 1'b0, 1'b0);
      end

      // Abort: reset asserted in the 4th RUN cycle; no done may follow.
      @(negedge clk);
      set_in(0, 8'hA5, 8'h3C, 1'b1, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) set_in(0, 8'(($urandom)), 8'($urandom), 1'($urandom), 1'b0);
      end
      check("abort_busy_before_reset", 64'(busy8), 64'd1);
      #2;
      rst = 1'b1;
      set_in(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      set_in(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      set_in(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      #1;
      check_reset_outputs("reset_async");
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         prev_res[d] = '0;
         set_in(d, 8'h00, 8'h00, 1'b0, 1'b0);
      end
      repeat (12) @(negedge clk);
      check("abort_idle_busy", 64'(busy8), 64'd0);
      check("abort_idle_result", 64'(get_res(0)), 64'd0);

      // Fresh operation after the abort: 0xC8 + 0x64 + 1 = 0x12D.
      run_op(0, 8'hC8, 8'h64, 1'b1, 9'h12D, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time bound, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_serial_adder
